// File: rtl/hash_light_ctrl_if.sv
// hash_light_ctrl_if
//   Bundles every handshake and bus signal around the hash controller:
//   the byte-wide message stream in (s_*), the hash-core request/response
//   pair (h_*), the byte-wide digest stream out (d_*), and the busy/err
//   status lines.
//   master : the controller's view (drives s_ready, h_start, h_m, d_valid,
//            d_data, busy, err).
//   slave  : the environment's view (message source, hash core, digest sink).
interface hash_light_ctrl_if;
   logic        s_valid;
   logic [7:0]  s_data;
   logic        s_ready;
   logic        h_start;
   logic [31:0] h_m;
   logic        h_done;
   logic [31:0] h_d;
   logic        d_valid;
   logic [7:0]  d_data;
   logic        d_ready;
   logic        busy;
   logic        err;

   modport master (
      input  s_valid, s_data, h_done, h_d, d_ready,
      output s_ready, h_start, h_m, d_valid, d_data, busy, err
   );

   modport slave (
      output s_valid, s_data, h_done, h_d, d_ready,
      input  s_ready, h_start, h_m, d_valid, d_data, busy, err
   );
endinterface

// File: rtl/hash_light_ctrl.sv
// hash_light_ctrl
//   Collects four message bytes into a 32-bit block, kicks a hash core with
//   a one-cycle start pulse, waits (bounded by TIMEOUT cycles) for the core
//   to finish, then streams the four digest bytes out, most significant first.
//   A core that never answers sets the sticky err flag and the block is dropped.
// Ports
//   clk : single clock, rising edge
//   rst : synchronous active-high reset
//   bus : hash_light_ctrl_if.master
//         s_valid/s_data/s_ready  message byte stream in
//         h_start/h_m             request to the hash core
//         h_done/h_d              response from the hash core
//         d_valid/d_data/d_ready  digest byte stream out
//         busy                    high in every state except LOAD
//         err                     sticky timeout flag
module hash_light_ctrl #(
   parameter int unsigned TIMEOUT = 255
) (
   input logic                clk,
   input logic                rst,
   hash_light_ctrl_if.master  bus
);

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2,
      EMIT  = 2'd3
   } state_t;

   // The wait counter starts at 0 on the first WAIT cycle, so the last
   // permitted WAIT cycle is the one where it holds TIMEOUT-1.
   localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

   state_t      state;
   state_t      state_next;
   logic [1:0]  byte_cnt;
   logic [1:0]  dig_idx;
   logic [15:0] wait_cnt;
   logic [31:0] m_reg;
   logic [31:0] digest;
   logic        err_reg;

   logic        s_xfer;
   logic        d_xfer;
   logic        timeout_hit;

   // Handshake qualifiers; h_done only matters while waiting, and a
   // completion on the last allowed cycle still wins over the timeout.
   always_comb begin
      s_xfer      = bus.s_valid && (state == LOAD);
      d_xfer      = bus.d_ready && (state == EMIT);
      timeout_hit = (state == WAIT) && !bus.h_done && (wait_cnt == WAIT_LAST);
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= LOAD;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic.
   always_comb begin
      state_next = state;
      case (state)
         LOAD: begin
            if (s_xfer && (byte_cnt == 2'd3)) begin
               state_next = START;
            end
         end
         START: begin
            state_next = WAIT;
         end
         WAIT: begin
            if (bus.h_done) begin
               state_next = EMIT;
            end else if (timeout_hit) begin
               state_next = LOAD;
            end
         end
         EMIT: begin
            if (d_xfer && (dig_idx == 2'd3)) begin
               state_next = LOAD;
            end
         end
         default: begin
            state_next = LOAD;
         end
      endcase
   end

   // Datapath: message assembly, wait counter, digest capture, digest
   // index and the sticky error flag. Both 2-bit counters wrap naturally
   // after their fourth step.
   always_ff @(posedge clk) begin
      if (rst) begin
         byte_cnt <= 2'd0;
         dig_idx  <= 2'd0;
         wait_cnt <= 16'd0;
         m_reg    <= 32'd0;
         digest   <= 32'd0;
         err_reg  <= 1'b0;
      end else begin
         if (s_xfer) begin
            case (byte_cnt)
               2'd0:    m_reg[31:24] <= bus.s_data;
               2'd1:    m_reg[23:16] <= bus.s_data;
               2'd2:    m_reg[15:8]  <= bus.s_data;
               default: m_reg[7:0]   <= bus.s_data;
            endcase
            byte_cnt <= byte_cnt + 2'd1;
         end

         if (state == WAIT) begin
            wait_cnt <= wait_cnt + 16'd1;
         end else begin
            wait_cnt <= 16'd0;
         end

         if ((state == WAIT) && bus.h_done) begin
            digest <= bus.h_d;
         end

         if (timeout_hit) begin
            err_reg <= 1'b1;
         end

         if (d_xfer) begin
            dig_idx <= dig_idx + 2'd1;
         end
      end
   end

   // Outputs are pure functions of state and registers; d_data is forced
   // to zero outside EMIT so nothing stale leaks onto the digest bus.
   always_comb begin
      bus.s_ready = (state == LOAD);
      bus.h_start = (state == START);
      bus.h_m     = m_reg;
      bus.d_valid = (state == EMIT);
      bus.busy    = (state != LOAD);
      bus.err     = err_reg;
      bus.d_data  = 8'd0;
      if (state == EMIT) begin
         case (dig_idx)
            2'd0:    bus.d_data = digest[31:24];
            2'd1:    bus.d_data = digest[23:16];
            2'd2:    bus.d_data = digest[15:8];
            default: bus.d_data = digest[7:0];
         endcase
      end
   end

endmodule
